// File: rtl/branch_sequencer.sv
// Program-flow sequencer: decodes instruction flow class, updates the PC and drives a
// return-stack RAM. Optional macro BSEQ_ERR_HALT_EN parks the FSM in a HALT state on stack errors.
module branch_sequencer #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned SP_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [ADDR_W+2:0] instr,
   output logic [ADDR_W-1:0] pc,
   output logic              stk_we,
   output logic [SP_W-1:0]   stk_addr,
   output logic [ADDR_W-1:0] stk_wdata,
   input  logic [ADDR_W-1:0] stk_rdata,
   output logic [SP_W:0]     depth,
   output logic              ovf_err,
   output logic              udf_err,
   input  logic              err_clr
);

   localparam logic [2:0] ClsJmp  = 3'b001;
   localparam logic [2:0] ClsSkip = 3'b010;
   localparam logic [2:0] ClsCall = 3'b011;
   localparam logic [2:0] ClsRet  = 3'b100;

   localparam logic [ADDR_W-1:0] PcOne    = 1;
   localparam logic [ADDR_W-1:0] PcTwo    = 2;
   localparam logic [SP_W-1:0]   SpOne    = 1;
   localparam logic [SP_W:0]     DepOne   = 1;
   localparam logic [SP_W:0]     DepthFull = DEPTH[SP_W:0];

`ifdef BSEQ_ERR_HALT_EN
   typedef enum logic [1:0] {StIdle, StExec, StRdWait, StHalt} state_e;
`else
   typedef enum logic [1:0] {StIdle, StExec, StRdWait} state_e;
`endif

   state_e              state_q, state_d;
   logic [ADDR_W+2:0]   instr_q;
   logic                instr_ld;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic [SP_W:0]       depth_q, depth_d;
   logic                ovf_q, ovf_d, ovf_set;
   logic                udf_q, udf_d, udf_set;

   logic [2:0]          cls;
   logic [ADDR_W-1:0]   target;
   logic [ADDR_W-1:0]   pc_inc;

   assign cls    = instr_q[ADDR_W+2:ADDR_W];
   assign target = instr_q[ADDR_W-1:0];
   assign pc_inc = pc_q + PcOne;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      sp_d        = sp_q;
      depth_d     = depth_q;
      ovf_set     = 1'b0;
      udf_set     = 1'b0;
      instr_ld    = 1'b0;
      instr_ready = 1'b0;
      stk_we      = 1'b0;
      stk_addr    = '0;
      stk_wdata   = '0;

      unique case (state_q)
         StIdle: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               instr_ld = 1'b1;
               state_d  = StExec;
            end
         end

         StExec: begin
            state_d = StIdle;
            case (cls)
               ClsJmp:  pc_d = target;
               ClsSkip: pc_d = pc_q + PcTwo;
               ClsCall: begin
                  if (depth_q == DepthFull) begin
                     ovf_set = 1'b1;
`ifdef BSEQ_ERR_HALT_EN
                     state_d = StHalt;
`else
                     pc_d    = pc_inc;
`endif
                  end else begin
                     stk_we    = 1'b1;
                     stk_addr  = sp_q;
                     stk_wdata = pc_inc;
                     sp_d      = sp_q + SpOne;
                     depth_d   = depth_q + DepOne;
                     pc_d      = target;
                  end
               end
               ClsRet: begin
                  if (depth_q == '0) begin
                     udf_set = 1'b1;
`ifdef BSEQ_ERR_HALT_EN
                     state_d = StHalt;
`else
                     pc_d    = pc_inc;
`endif
                  end else begin
                     // Address goes out now; the RAM returns the entry during RDWAIT.
                     stk_addr = sp_q - SpOne;
                     state_d  = StRdWait;
                  end
               end
               default: pc_d = pc_inc;
            endcase
         end

         StRdWait: begin
            pc_d    = stk_rdata;
            sp_d    = sp_q - SpOne;
            depth_d = depth_q - DepOne;
            state_d = StIdle;
         end

`ifdef BSEQ_ERR_HALT_EN
         StHalt: begin
            if (err_clr) state_d = StIdle;
         end
`endif

         default: state_d = StIdle;
      endcase

      // A new error in the same cycle as err_clr keeps its flag set.
      ovf_d = (ovf_q & ~err_clr) | ovf_set;
      udf_d = (udf_q & ~err_clr) | udf_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         instr_q <= '0;
         pc_q    <= '0;
         sp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (instr_ld) instr_q <= instr;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign pc      = pc_q;
   assign depth   = depth_q;
   assign ovf_err = ovf_q;
   assign udf_err = udf_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed cases then random instructions against a
// queue-based model of the PC and return stack. Honours BSEQ_ERR_HALT_EN when defined.
module tb_branch_sequencer;

   localparam int ADDR_W = 14;
   localparam int DEPTH  = 8;
   localparam int SP_W   = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              instr_valid;
   logic              instr_ready;
   logic [16:0]       instr;
   logic [13:0]       pc;
   logic              stk_we;
   logic [2:0]        stk_addr;
   logic [13:0]       stk_wdata;
   logic [13:0]       stk_rdata;
   logic [3:0]        depth;
   logic              ovf_err;
   logic              udf_err;
   logic              err_clr;

   int errors = 0;
   int checks = 0;

   logic [13:0] ram [DEPTH];
   logic [13:0] m_pc;
   logic [13:0] m_stk [$];
   bit          m_ovf, m_udf;

   branch_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SP_W(SP_W)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .pc(pc), .stk_we(stk_we), .stk_addr(stk_addr), .stk_wdata(stk_wdata),
      .stk_rdata(stk_rdata), .depth(depth), .ovf_err(ovf_err), .udf_err(udf_err),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // External stack RAM: synchronous write, one-cycle synchronous read.
   always @(posedge clk) begin
      if (stk_we) ram[stk_addr] <= stk_wdata;
      stk_rdata <= ram[stk_addr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_arch(input string tag);
      check({tag, "_pc"}, 32'(pc), 32'(m_pc));
      check({tag, "_depth"}, 32'(depth), 32'(m_stk.size()));
      check({tag, "_ovf"}, 32'(ovf_err), 32'(m_ovf));
      check({tag, "_udf"}, 32'(udf_err), 32'(m_udf));
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check("clr_ovf", 32'(ovf_err), 0);
      check("clr_udf", 32'(udf_err), 0);
      check("clr_ready", 32'(instr_ready), 1);
   endtask

   task automatic do_instr(input logic [2:0] cls, input logic [13:0] tgt, input bit clr);
      int          n;
      bit          exp_we, is_ret, err;
      logic [2:0]  exp_addr;
      logic [13:0] exp_wd, pc_before;
      n = 0;
      while (instr_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", 32'(instr_ready), 1);
      instr       = {cls, tgt};
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;

      pc_before = m_pc;
      exp_we = 0; is_ret = 0; err = 0; exp_addr = '0; exp_wd = '0;
      if (clr) begin
         m_ovf = 0;
         m_udf = 0;
      end
      case (cls)
         3'd1: m_pc = tgt;
         3'd2: m_pc = m_pc + 14'd2;
         3'd3: begin
            if (m_stk.size() == DEPTH) begin
               err = 1; m_ovf = 1;
            end else begin
               exp_we   = 1;
               exp_addr = 3'(m_stk.size() % DEPTH);
               exp_wd   = m_pc + 14'd1;
               m_stk.push_back(exp_wd);
               m_pc     = tgt;
            end
         end
         3'd4: begin
            if (m_stk.size() == 0) begin
               err = 1; m_udf = 1;
            end else begin
               is_ret   = 1;
               exp_addr = 3'((m_stk.size() - 1) % DEPTH);
            end
         end
         default: m_pc = m_pc + 14'd1;
      endcase
`ifndef BSEQ_ERR_HALT_EN
      if (err) m_pc = m_pc + 14'd1;
`endif

      check("exec_ready", 32'(instr_ready), 0);
      check("exec_pc", 32'(pc), 32'(pc_before));
      check("exec_we", 32'(stk_we), 32'(exp_we));
      if (exp_we) begin
         check("exec_waddr", 32'(stk_addr), 32'(exp_addr));
         check("exec_wdata", 32'(stk_wdata), 32'(exp_wd));
      end
      if (is_ret) check("exec_raddr", 32'(stk_addr), 32'(exp_addr));

      if (clr) err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      if (is_ret) begin
         check("rdwait_ready", 32'(instr_ready), 0);
         check("rdwait_pc", 32'(pc), 32'(pc_before));
         m_pc = m_stk.pop_back();
         tick();
      end

      chk_arch("done");
      check("done_we", 32'(stk_we), 0);
`ifdef BSEQ_ERR_HALT_EN
      check("done_ready", 32'(instr_ready), err ? 0 : 1);
      if (err) begin
         tick();
         tick();
         check("halt_ready", 32'(instr_ready), 0);
         check("halt_pc", 32'(pc), 32'(m_pc));
         clear_err();
      end
`else
      check("done_ready", 32'(instr_ready), 1);
`endif
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = '0; err_clr = 1'b0;
      m_pc = '0; m_ovf = 0; m_udf = 0;
      tick();
      tick();
      rst = 1'b0;
      chk_arch("reset");
      check("reset_ready", 32'(instr_ready), 1);
      check("reset_we", 32'(stk_we), 0);

      // PC wrap cases
      do_instr(3'd1, 14'h3FFF, 0);
      do_instr(3'd0, 14'h0000, 0);
      check("nop_wrap", 32'(pc), 32'h0000);
      do_instr(3'd1, 14'h3FFF, 0);
      do_instr(3'd2, 14'h0000, 0);
      check("skip_wrap1", 32'(pc), 32'h0001);
      do_instr(3'd1, 14'h3FFE, 0);
      do_instr(3'd2, 14'h0000, 0);
      check("skip_wrap0", 32'(pc), 32'h0000);

      // CALL then RET
      do_instr(3'd1, 14'h0010, 0);
      do_instr(3'd3, 14'h0100, 0);
      check("call_pc", 32'(pc), 32'h0100);
      do_instr(3'd4, 14'h0000, 0);
      check("ret_pc", 32'(pc), 32'h0011);

      // Fill the stack, then overflow
      do_instr(3'd1, 14'h0000, 0);
      for (int i = 0; i < DEPTH; i++) do_instr(3'd3, 14'($urandom), 0);
      do_instr(3'd1, 14'h0200, 0);
      do_instr(3'd3, 14'h0300, 0);
      check("ovf_depth", 32'(depth), DEPTH);
`ifndef BSEQ_ERR_HALT_EN
      check("ovf_pc", 32'(pc), 32'h0201);
      clear_err();
`else
      check("ovf_pc", 32'(pc), 32'h0200);
`endif
      for (int i = 0; i < DEPTH; i++) do_instr(3'd4, 14'h0000, 0);

      // Underflow, clear, and clear colliding with a new error
      do_instr(3'd1, 14'h0005, 0);
      do_instr(3'd4, 14'h0000, 0);
`ifndef BSEQ_ERR_HALT_EN
      check("udf_pc", 32'(pc), 32'h0006);
      clear_err();
      do_instr(3'd4, 14'h0000, 0);
      do_instr(3'd4, 14'h0000, 1);
      check("udf_collide", 32'(udf_err), 1);
      do_instr(3'd0, 14'h0000, 1);
      check("udf_clr_exec", 32'(udf_err), 0);
`else
      check("udf_pc", 32'(pc), 32'h0005);
`endif

      // Random instruction stream
      for (int i = 0; i < 150; i++)
         do_instr(3'($urandom_range(0, 7)), 14'($urandom), ($urandom_range(0, 9) == 0));

      // Reset during RDWAIT
      do_instr(3'd3, 14'h0123, 0);
      instr       = {3'd4, 14'h0000};
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      check("rst_exec_raddr", 32'(stk_addr), 32'((m_stk.size() - 1) % DEPTH));
      tick();
      check("rst_rdwait_ready", 32'(instr_ready), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = '0;
      m_stk.delete();
      m_ovf = 0;
      m_udf = 0;
      chk_arch("rst_mid");
      check("rst_mid_ready", 32'(instr_ready), 1);
      check("rst_mid_we", 32'(stk_we), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
